// File: rtl/buf_load_arb.sv
// Round-robin load arbiter: grants one of four buffer load engines and streams
// DRAM beats into the granted buffer's write port at sequential word addresses.
module buf_load_arb #(
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_ibuf,
    input  logic              req_wbuf,
    input  logic              req_bbuf,
    input  logic              req_obuf,
    input  logic [13:0]       base_ibuf,
    input  logic [11:0]       base_wbuf,
    input  logic [10:0]       base_bbuf,
    input  logic [14:0]       base_obuf,
    input  logic [LEN_W-1:0]  len_ibuf,
    input  logic [LEN_W-1:0]  len_wbuf,
    input  logic [LEN_W-1:0]  len_bbuf,
    input  logic [LEN_W-1:0]  len_obuf,
    output logic              gnt_ibuf,
    output logic              gnt_wbuf,
    output logic              gnt_bbuf,
    output logic              gnt_obuf,
    output logic              done_ibuf,
    output logic              done_wbuf,
    output logic              done_bbuf,
    output logic              done_obuf,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_ready,
    output logic [13:0]       tag_mem_write_addr_ibuf,
    output logic [11:0]       tag_mem_write_addr_wbuf,
    output logic [10:0]       tag_mem_write_addr_bbuf,
    output logic [14:0]       tag_mem_write_addr_obuf,
    output logic              mem_write_req_ibuf,
    output logic              mem_write_req_wbuf,
    output logic              mem_write_req_bbuf,
    output logic              mem_write_req_obuf,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              busy,
    output logic [1:0]        sel,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d, sel_q, sel_d;
    logic [14:0]      addr_q, addr_d, addr_mask, base_win;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_win;
    logic [3:0]       req_vec, sel_oh, wreq_q;
    logic [1:0]       win, idx;
    logic             found, hs;

    assign req_vec = {req_obuf, req_bbuf, req_wbuf, req_ibuf};
    // Beat transfers on rd_valid & rd_ready; rd_ready is high only while bursting.
    assign hs      = rd_valid && (state_q == S_BURST);
    assign sel_oh  = 4'b0001 << sel_q;

    // First requester at or after the pointer, wrapping ibuf..obuf.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req_vec[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        base_win = {1'b0, base_ibuf};
        len_win  = len_ibuf;
        case (win)
            2'd1:    begin base_win = {3'b0, base_wbuf}; len_win = len_wbuf; end
            2'd2:    begin base_win = {4'b0, base_bbuf}; len_win = len_bbuf; end
            2'd3:    begin base_win = base_obuf;         len_win = len_obuf; end
            default: ;
        endcase
    end

    // Address wraps at the owning buffer's address width.
    always_comb begin
        case (sel_q)
            2'd0:    addr_mask = 15'h3FFF;
            2'd1:    addr_mask = 15'h0FFF;
            2'd2:    addr_mask = 15'h07FF;
            default: addr_mask = 15'h7FFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    sel_d   = win;
                    addr_d  = base_win;
                    cnt_d   = len_win;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: state_d = S_BURST;
            S_BURST: begin
                if (hs) begin
                    addr_d = (addr_q + 15'd1) & addr_mask;
                    if (cnt_q == '0) state_d = S_DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: begin
                ptr_d   = sel_q + 2'd1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wreq_q                  <= '0;
            mem_write_data          <= '0;
            tag_mem_write_addr_ibuf <= '0;
            tag_mem_write_addr_wbuf <= '0;
            tag_mem_write_addr_bbuf <= '0;
            tag_mem_write_addr_obuf <= '0;
        end else begin
            wreq_q <= hs ? sel_oh : 4'b0000;
            if (hs) begin
                mem_write_data <= rd_data;
                case (sel_q)
                    2'd0:    tag_mem_write_addr_ibuf <= addr_q[13:0];
                    2'd1:    tag_mem_write_addr_wbuf <= addr_q[11:0];
                    2'd2:    tag_mem_write_addr_bbuf <= addr_q[10:0];
                    default: tag_mem_write_addr_obuf <= addr_q;
                endcase
            end
        end
    end

    assign {gnt_obuf, gnt_bbuf, gnt_wbuf, gnt_ibuf}     = (state_q == S_GRANT) ? sel_oh : 4'b0000;
    assign {done_obuf, done_bbuf, done_wbuf, done_ibuf} = (state_q == S_DONE)  ? sel_oh : 4'b0000;
    assign {mem_write_req_obuf, mem_write_req_bbuf,
            mem_write_req_wbuf, mem_write_req_ibuf}     = wreq_q;
    assign rd_ready  = (state_q == S_BURST);
    assign busy      = (state_q != S_IDLE);
    assign sel       = sel_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_buf_load_arb.sv
// Bench for buf_load_arb: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of arbitration and bursts.
module tb_buf_load_arb;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req_v;
    logic [14:0]       base_v [4];
    logic [LEN_W-1:0]  len_v [4];
    logic [3:0]        gnt_v, done_v, wreq_v;
    logic              rd_valid, rd_ready, busy;
    logic [DATA_W-1:0] rd_data, mem_write_data;
    logic [13:0]       wa_ibuf;
    logic [11:0]       wa_wbuf;
    logic [10:0]       wa_bbuf;
    logic [14:0]       wa_obuf;
    logic [1:0]        sel, dbg_state;

    buf_load_arb #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .req_ibuf(req_v[0]), .req_wbuf(req_v[1]), .req_bbuf(req_v[2]), .req_obuf(req_v[3]),
        .base_ibuf(base_v[0][13:0]), .base_wbuf(base_v[1][11:0]),
        .base_bbuf(base_v[2][10:0]), .base_obuf(base_v[3]),
        .len_ibuf(len_v[0]), .len_wbuf(len_v[1]), .len_bbuf(len_v[2]), .len_obuf(len_v[3]),
        .gnt_ibuf(gnt_v[0]), .gnt_wbuf(gnt_v[1]), .gnt_bbuf(gnt_v[2]), .gnt_obuf(gnt_v[3]),
        .done_ibuf(done_v[0]), .done_wbuf(done_v[1]), .done_bbuf(done_v[2]), .done_obuf(done_v[3]),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .tag_mem_write_addr_ibuf(wa_ibuf), .tag_mem_write_addr_wbuf(wa_wbuf),
        .tag_mem_write_addr_bbuf(wa_bbuf), .tag_mem_write_addr_obuf(wa_obuf),
        .mem_write_req_ibuf(wreq_v[0]), .mem_write_req_wbuf(wreq_v[1]),
        .mem_write_req_bbuf(wreq_v[2]), .mem_write_req_obuf(wreq_v[3]),
        .mem_write_data(mem_write_data), .busy(busy), .sel(sel), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int aw [4] = '{14, 12, 11, 15};

    // Reference model: who owns the buffer port, where the burst stands.
    int          m_owner, m_left, m_addr, m_ptr, m_sel, m_hs, m_wbuf;
    bit          m_granting, m_finishing, m_wr;
    int          m_waddr [4];
    logic [255:0] m_wdata;

    // Requester-side stimulus state.
    bit  pend [4];
    int  cool [4];
    bit  keep_req = 0;
    bit  toggle_ph = 1;
    int  valid_mode = 0;

    int  obs_gnt_q[$];
    int  obs_gnt_cyc[$];
    int  n_wr [4];
    logic [14:0] exp_q[$];
    logic [14:0] obs_bbuf_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [14:0] obs_addr(input int i);
        case (i)
            0: return {1'b0, wa_ibuf};
            1: return {3'b0, wa_wbuf};
            2: return {4'b0, wa_bbuf};
            default: return wa_obuf;
        endcase
    endfunction

    function automatic bit exp_ready();
        return (m_owner >= 0) && !m_granting && !m_finishing;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_addr = 0; m_ptr = 0; m_sel = 0; m_hs = 0;
        m_granting = 0; m_finishing = 0; m_wr = 0; m_wbuf = 0; m_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            m_waddr[i] = 0;
            pend[i] = 0;
            cool[i] = 0;
        end
    endtask

    task automatic check_outputs();
        chk("busy", busy, m_owner >= 0);
        chk("sel", sel, m_sel);
        chk("rd_ready", rd_ready, exp_ready());
        chk("wdata", mem_write_data, m_wdata);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("gnt%0d", i), gnt_v[i], m_granting && m_owner == i);
            chk($sformatf("done%0d", i), done_v[i], m_finishing && m_owner == i);
            chk($sformatf("wreq%0d", i), wreq_v[i], m_wr && m_wbuf == i);
            chk($sformatf("waddr%0d", i), obs_addr(i), m_waddr[i]);
            if (gnt_v[i]) begin
                obs_gnt_q.push_back(i);
                obs_gnt_cyc.push_back(cyc);
            end
            if (wreq_v[i]) n_wr[i]++;
        end
        if (wreq_v[2]) obs_bbuf_q.push_back({4'b0, wa_bbuf});
    endtask

    task automatic drive_and_advance();
        bit hs;
        bit found;
        int c;
        for (int i = 0; i < 4; i++) if (cool[i] > 0) cool[i]--;
        if (m_finishing && !keep_req) begin
            pend[m_owner] = 0;
            cool[m_owner] = 2;
        end
        case (valid_mode)
            0: rd_valid = 1'b1;
            1: begin rd_valid = toggle_ph; toggle_ph = !toggle_ph; end
            2: rd_valid = 1'($urandom_range(0, 1));
            default: rd_valid = 1'b0;
        endcase
        rd_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) req_v[i] = pend[i];

        hs = exp_ready() && rd_valid;
        m_wr = hs;
        if (hs) begin
            m_wbuf = m_owner;
            m_waddr[m_owner] = m_addr;
            m_wdata = rd_data;
        end
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && req_v[c]) begin
                    found = 1;
                    m_owner = c;
                    m_sel = c;
                    m_addr = int'(base_v[c]) % (1 << aw[c]);
                    m_left = int'(len_v[c]) + 1;
                    m_granting = 1;
                    m_hs = 0;
                end
            end
        end else if (m_granting) begin
            m_granting = 0;
        end else if (m_finishing) begin
            m_finishing = 0;
            m_ptr = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (hs) begin
            m_addr = (m_addr + 1) % (1 << aw[m_owner]);
            m_left--;
            m_hs++;
            if (m_left == 0) m_finishing = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_cycle();
        check_outputs();
        drive_and_advance();
        tick();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        while ((m_owner >= 0 || pend[0] || pend[1] || pend[2] || pend[3]) && n < budget) begin
            run_cycle();
            n++;
        end
        chk({"timeout_", tag}, n < budget, 1'b1);
        run_cycles(2);
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < 4; i++) begin
            if (!pend[i] && cool[i] == 0 && $urandom_range(0, 7) == 0) begin
                pend[i] = 1;
                base_v[i] = 15'($urandom);
                len_v[i] = 8'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        int w0, wall, gi;
        reset = 1'b0;
        req_v = '0;
        rd_valid = 1'b0;
        rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            base_v[i] = '0;
            len_v[i] = '0;
            n_wr[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b1;

        // Round robin from reset: all four held high, single-beat bursts.
        keep_req = 1;
        valid_mode = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1;
            len_v[i] = 8'd0;
            base_v[i] = 15'($urandom);
        end
        obs_gnt_q.delete();
        obs_gnt_cyc.delete();
        run_cycles(24);
        keep_req = 0;
        for (int i = 0; i < 4; i++) pend[i] = 0;
        run_until_idle(20, "rr");
        chk("rr_count", obs_gnt_q.size() >= 5, 1'b1);
        if (obs_gnt_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("rr_order%0d", k), obs_gnt_q[k], k % 4);
                if (k > 0) chk($sformatf("rr_gap%0d", k), obs_gnt_cyc[k] - obs_gnt_cyc[k-1], 4);
            end
        end

        // Single wbuf burst of 4 beats at 0x010.
        w0 = n_wr[1];
        wall = n_wr[0] + n_wr[2] + n_wr[3];
        gi = obs_gnt_q.size();
        base_v[1] = 15'h010;
        len_v[1] = 8'd3;
        pend[1] = 1;
        run_until_idle(30, "single");
        chk("single_writes", n_wr[1] - w0, 4);
        chk("single_others", n_wr[0] + n_wr[2] + n_wr[3] - wall, 0);
        chk("single_gnt_n", obs_gnt_q.size() - gi, 1);
        if (obs_gnt_q.size() > gi) chk("single_gnt_who", obs_gnt_q[gi], 1);

        // Stalled bbuf burst wrapping past the top of its 11-bit space.
        obs_bbuf_q.delete();
        exp_q = '{15'h7FE, 15'h7FF, 15'h000, 15'h001};
        valid_mode = 1;
        toggle_ph = 1;
        base_v[2] = 15'h7FE;
        len_v[2] = 8'd3;
        pend[2] = 1;
        run_until_idle(40, "wrap");
        chk("wrap_writes", obs_bbuf_q.size(), 4);
        while (exp_q.size() > 0 && obs_bbuf_q.size() > 0)
            chk("wrap_addr", obs_bbuf_q.pop_front(), exp_q.pop_front());

        // Maximum-length obuf burst.
        valid_mode = 0;
        w0 = n_wr[3];
        base_v[3] = 15'h7F80;
        len_v[3] = 8'd255;
        pend[3] = 1;
        run_until_idle(300, "maxlen");
        chk("maxlen_writes", n_wr[3] - w0, 256);

        // Stray DRAM beats with nobody requesting.
        wall = n_wr[0] + n_wr[1] + n_wr[2] + n_wr[3];
        valid_mode = 0;
        run_cycles(6);
        chk("stray_writes", n_wr[0] + n_wr[1] + n_wr[2] + n_wr[3] - wall, 0);

        // Reset after two of eight ibuf beats.
        base_v[0] = 15'h0123;
        len_v[0] = 8'd7;
        pend[0] = 1;
        begin
            int n = 0;
            while (m_hs < 2 && n < 20) begin
                run_cycle();
                n++;
            end
            chk("rst_reach2", n < 20, 1'b1);
        end
        reset = 1'b0;
        #1;
        model_reset();
        req_v = '0;
        check_outputs();
        tick();
        check_outputs();
        reset = 1'b1;
        wall = n_wr[0] + n_wr[1] + n_wr[2] + n_wr[3];
        run_cycles(5);
        chk("rst_nowrite", n_wr[0] + n_wr[1] + n_wr[2] + n_wr[3] - wall, 0);
        gi = obs_gnt_q.size();
        base_v[1] = 15'h0ABC;
        len_v[1] = 8'd2;
        pend[1] = 1;
        run_until_idle(30, "rst_new");
        if (obs_gnt_q.size() > gi) chk("rst_first_gnt", obs_gnt_q[gi], 1);
        else chk("rst_gnt_seen", 1'b0, 1'b1);

        // Random traffic with random stalls.
        valid_mode = 2;
        for (int i = 0; i < 800; i++) begin
            rand_reqs();
            run_cycle();
        end
        run_until_idle(400, "random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
